// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants and types for the RV32I-subset multi-cycle controller.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  // Instruction class, one-hot; all-zero means unsupported.
  typedef struct packed {
    logic r;
    logic i;
    logic ld;
    logic st;
    logic br;
  } cls_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the controller (master) and the datapath (slave).
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [31:0]      inst;
  logic             zero;
  logic             mem_ready;
  logic [1:0]       ALUOp;
  logic             ALUSrc;
  logic [2:0]       ALUFunct3;
  logic [6:0]       ALUFunct7;
  logic             PCWrite;
  logic             PCSrc;
  logic             IRWrite;
  logic             MemRead;
  logic             IorD;
  logic             MemWrite;
  logic             RegWrite;
  logic             MemtoReg;
  logic             illegal;
  logic [CNT_W-1:0] InstRetired;
  logic [2:0]       state;

  modport master (
    input  inst, zero, mem_ready,
    output ALUOp, ALUSrc, ALUFunct3, ALUFunct7, PCWrite, PCSrc, IRWrite,
           MemRead, IorD, MemWrite, RegWrite, MemtoReg, illegal, InstRetired, state
  );

  modport slave (
    output inst, zero, mem_ready,
    input  ALUOp, ALUSrc, ALUFunct3, ALUFunct7, PCWrite, PCSrc, IRWrite,
           MemRead, IorD, MemWrite, RegWrite, MemtoReg, illegal, InstRetired, state
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Opcode/funct3 classifier: one-hot instruction class plus a legal bit.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  output cls_t       cls_o,
  output logic       legal_o
);

  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OP_R:      cls_o.r  = 1'b1;
      OP_I:      cls_o.i  = 1'b1;
      OP_LOAD:   cls_o.ld = 1'b1;
      OP_STORE:  cls_o.st = 1'b1;
      // only beq (000) and bne (001) are implemented
      OP_BRANCH: cls_o.br = (funct3_i[2:1] == 2'b00);
      default:   cls_o    = '0;
    endcase
  end

  assign legal_o = |cls_o;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout trap.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             ill_q, ill_d;
  cls_t             cls;
  logic             legal, take, mem_wait, tmo_hit, retire;
  logic             unused_inst;

  multicycle_ctrl_decode u_dec (
    .opcode_i (bus.inst[6:0]),
    .funct3_i (bus.inst[14:12]),
    .cls_o    (cls),
    .legal_o  (legal)
  );

  assign unused_inst = ^{bus.inst[24:15], bus.inst[11:7]};

  assign take     = bus.inst[12] ? !bus.zero : bus.zero;
  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM)) && !bus.mem_ready;
  // Counter is zero on entry to FETCH/MEM because every other state clears it.
  assign tmo_d    = mem_wait ? tmo_q + TMO_W'(1) : '0;
  assign tmo_hit  = (TIMEOUT != 0) && mem_wait && (tmo_d == TMO_W'(TIMEOUT));
  assign retire   = ((state_q == S_EXEC) && cls.br) ||
                    ((state_q == S_MEM) && cls.st && bus.mem_ready) ||
                    (state_q == S_WB);
  assign ret_d    = retire ? ret_q + CNT_W'(1) : ret_q;
  assign ill_d    = ill_q | (state_d == S_TRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      ret_q <= '0;
      ill_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      ret_q <= ret_d;
      ill_q <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
                else if (tmo_hit)  state_d = S_TRAP;
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC:   state_d = cls.br ? S_FETCH : (cls.ld || cls.st) ? S_MEM : S_WB;
      S_MEM:    if (bus.mem_ready) state_d = cls.st ? S_FETCH : S_WB;
                else if (tmo_hit)  state_d = S_TRAP;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_TRAP;
    endcase
  end

  always_comb begin
    bus.ALUOp     = ALUOP_ADD;
    bus.ALUSrc    = 1'b0;
    bus.ALUFunct3 = 3'b000;
    bus.ALUFunct7 = 7'b0000000;
    bus.PCWrite   = 1'b0;
    bus.PCSrc     = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.MemRead   = 1'b0;
    bus.IorD      = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.MemtoReg  = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      S_EXEC: begin
        if (cls.r) begin
          bus.ALUOp     = ALUOP_FUNC;
          bus.ALUFunct3 = bus.inst[14:12];
          bus.ALUFunct7 = bus.inst[31:25];
        end else if (cls.i) begin
          bus.ALUOp     = ALUOP_FUNC;
          bus.ALUSrc    = 1'b1;
          bus.ALUFunct3 = bus.inst[14:12];
        end else if (cls.ld || cls.st) begin
          bus.ALUSrc    = 1'b1;
        end else if (cls.br) begin
          bus.ALUOp     = ALUOP_SUB;
          bus.PCWrite   = take;
          bus.PCSrc     = take;
        end
      end
      S_MEM: begin
        bus.IorD     = 1'b1;
        bus.MemRead  = cls.ld;
        bus.MemWrite = cls.st;
      end
      S_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = cls.ld;
      end
      default: ;
    endcase
  end

  assign bus.illegal     = ill_q;
  assign bus.InstRetired = ret_q;
  assign bus.state       = state_q;

endmodule
